// File: rtl/ip_tx_pkg.sv
// Shared constants and FSM state encoding for the IPv4 transmit framer (ip_tx)
// and its header checksum helper.
package ip_tx_pkg;

  localparam logic [7:0]  C_IP_VER_IHL = 8'h45;
  localparam int unsigned C_IP_HDR_LEN = 20;
  localparam logic [15:0] C_IP_FLAGS   = 16'h4000;
  localparam logic [7:0]  C_PROTO_UDP  = 8'd17;
  localparam logic [7:0]  C_PROTO_ICMP = 8'd1;
  localparam int unsigned C_HDR_WORDS  = C_IP_HDR_LEN / 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUM,
    ST_FOLD,
    ST_HEAD,
    ST_DATA
  } state_e;

endpackage

// File: rtl/ip_checksum.sv
// IPv4 header checksum: registered 20-bit sum of ten header words on i_start,
// then a registered end-around-carry fold and inversion; o_done pulses with the result.
module ip_checksum
  import ip_tx_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [16*C_HDR_WORDS-1:0] i_words,
  output logic [15:0]               o_csum,
  output logic                      o_done
);

  logic [19:0] sum_d, sum_q;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic [15:0] csum_d, csum_q;
  logic        fold_q;
  logic        done_q;

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < C_HDR_WORDS; i++) begin
      sum_d = sum_d + {4'h0, i_words[16*i +: 16]};
    end
    // Second fold only ever adds the single carry left over by the first.
    fold1  = {1'b0, sum_q[15:0]} + {13'h0, sum_q[19:16]};
    fold2  = fold1[15:0] + {15'h0, fold1[16]};
    csum_d = ~fold2;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_q  <= '0;
      fold_q <= 1'b0;
      csum_q <= '0;
      done_q <= 1'b0;
    end else begin
      if (i_start) sum_q <= sum_d;
      if (fold_q)  csum_q <= csum_d;
      fold_q <= i_start;
      done_q <= fold_q;
    end
  end

  assign o_csum = csum_q;
  assign o_done = done_q;

endmodule

// File: rtl/ip_tx.sv
// IPv4 transmit framer: arbitrates ICMP/UDP payload streams, prepends a 20-byte header.
// Define IP_TX_ID_INC_EN to make Identification count completed packets (else 0).
module ip_tx
  import ip_tx_pkg::*;
#(
  parameter logic [31:0] P_ST_TARGET_IP = {8'd192, 8'd168, 8'd1, 8'd0},
  parameter logic [31:0] P_ST_SOURCE_IP = {8'd192, 8'd168, 8'd1, 8'd1},
  parameter logic [7:0]  P_TTL          = 8'd64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_target_ip,
  input  logic        i_target_valid,
  input  logic [31:0] i_source_ip,
  input  logic        i_source_valid,
  input  logic [7:0]  i_udp_data,
  input  logic [15:0] i_udp_len,
  input  logic        i_udp_last,
  input  logic        i_udp_valid,
  output logic        o_udp_ready,
  input  logic [7:0]  i_icmp_data,
  input  logic [15:0] i_icmp_len,
  input  logic        i_icmp_last,
  input  logic        i_icmp_valid,
  output logic        o_icmp_ready,
  output logic [7:0]  o_mac_data,
  output logic [15:0] o_mac_len,
  output logic        o_mac_last,
  output logic        o_mac_valid
);

  state_e      state_q, state_d;
  logic        sel_icmp_q, sel_icmp_d;
  logic [15:0] len_q, len_d;
  logic [15:0] tot_len_q, tot_len_d;
  logic [7:0]  proto_q, proto_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [15:0] pkt_id_q, pkt_id_d;
  logic [15:0] id_ctr_q, id_ctr_d;
  logic [31:0] target_ip_q, target_ip_d;
  logic [31:0] source_ip_q, source_ip_d;
  logic [4:0]  hdr_cnt_q, hdr_cnt_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;
  logic [15:0] hdr_csum_q, hdr_csum_d;
  logic [7:0]  mac_data_q, mac_data_d;
  logic [15:0] mac_len_q, mac_len_d;
  logic        mac_last_q, mac_last_d;
  logic        mac_valid_q, mac_valid_d;

  logic [16*C_HDR_WORDS-1:0] hdr_words;
  logic [19:0][7:0]          tx_hdr;
  logic [4:0]                tx_idx;
  logic [7:0]                tx_byte;
  logic [15:0]               csum;
  logic                      csum_done;
  logic                      pay_phase;
  logic                      pay_valid;
  logic                      pay_last;
  logic [7:0]                pay_data;
  logic                      accept;

  assign hdr_words = {C_IP_VER_IHL, 8'h00, tot_len_q, pkt_id_q, C_IP_FLAGS,
                      P_TTL, proto_q, 16'h0000, src_q, dst_q};
  assign tx_hdr    = {C_IP_VER_IHL, 8'h00, tot_len_q, pkt_id_q, C_IP_FLAGS,
                      P_TTL, proto_q, hdr_csum_q, src_q, dst_q};

  ip_checksum u_checksum (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (state_q == ST_SUM),
    .i_words (hdr_words),
    .o_csum  (csum),
    .o_done  (csum_done)
  );

  // Output is registered, so each cycle prepares the byte shown on the next one.
  assign tx_idx  = (state_q == ST_FOLD) ? 5'd0 : hdr_cnt_q + 5'd1;
  assign tx_byte = tx_hdr[5'd19 - tx_idx];

  assign pay_phase    = ((state_q == ST_HEAD) && (hdr_cnt_q == 5'd19)) || (state_q == ST_DATA);
  assign pay_valid    = sel_icmp_q ? i_icmp_valid : i_udp_valid;
  assign pay_last     = sel_icmp_q ? i_icmp_last  : i_udp_last;
  assign pay_data     = sel_icmp_q ? i_icmp_data  : i_udp_data;
  assign accept       = pay_phase && pay_valid;
  assign o_udp_ready  = pay_phase && !sel_icmp_q;
  assign o_icmp_ready = pay_phase && sel_icmp_q;

  always_comb begin
    state_d     = state_q;
    sel_icmp_d  = sel_icmp_q;
    len_d       = len_q;
    tot_len_d   = tot_len_q;
    proto_d     = proto_q;
    src_d       = src_q;
    dst_d       = dst_q;
    pkt_id_d    = pkt_id_q;
    id_ctr_d    = id_ctr_q;
    target_ip_d = target_ip_q;
    source_ip_d = source_ip_q;
    hdr_cnt_d   = hdr_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    hdr_csum_d  = hdr_csum_q;
    mac_len_d   = mac_len_q;
    mac_data_d  = '0;
    mac_last_d  = 1'b0;
    mac_valid_d = 1'b0;

    if (i_target_valid) target_ip_d = i_target_ip;
    if (i_source_valid) source_ip_d = i_source_ip;
    if (csum_done)      hdr_csum_d  = csum;

    unique case (state_q)
      ST_IDLE: begin
        if (i_icmp_valid || i_udp_valid) begin
          sel_icmp_d = i_icmp_valid;
          len_d      = i_icmp_valid ? i_icmp_len : i_udp_len;
          proto_d    = i_icmp_valid ? C_PROTO_ICMP : C_PROTO_UDP;
          tot_len_d  = len_d + 16'(C_IP_HDR_LEN);
          mac_len_d  = tot_len_d;
          src_d      = source_ip_q;
          dst_d      = target_ip_q;
          pkt_id_d   = id_ctr_q;
          hdr_cnt_d  = '0;
          pay_cnt_d  = '0;
          state_d    = ST_SUM;
        end
      end
      ST_SUM: state_d = ST_FOLD;
      ST_FOLD: begin
        mac_data_d  = tx_byte;
        mac_valid_d = 1'b1;
        state_d     = ST_HEAD;
      end
      ST_HEAD: begin
        if (hdr_cnt_q != 5'd19) begin
          mac_data_d  = tx_byte;
          mac_valid_d = 1'b1;
          hdr_cnt_d   = hdr_cnt_q + 5'd1;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: ;
      default: state_d = ST_IDLE;
    endcase

    // Payload bytes can already be taken while the final header byte is out.
    if (accept) begin
      pay_cnt_d   = pay_cnt_q + 16'd1;
      mac_data_d  = pay_data;
      mac_valid_d = 1'b1;
      if (pay_last || (pay_cnt_d == len_q)) begin
        mac_last_d = 1'b1;
        state_d    = ST_IDLE;
`ifdef IP_TX_ID_INC_EN
        id_ctr_d   = id_ctr_q + 16'd1;
`endif
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      sel_icmp_q  <= 1'b0;
      len_q       <= '0;
      tot_len_q   <= '0;
      proto_q     <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      pkt_id_q    <= '0;
      id_ctr_q    <= '0;
      target_ip_q <= P_ST_TARGET_IP;
      source_ip_q <= P_ST_SOURCE_IP;
      hdr_cnt_q   <= '0;
      pay_cnt_q   <= '0;
      hdr_csum_q  <= '0;
      mac_data_q  <= '0;
      mac_len_q   <= '0;
      mac_last_q  <= 1'b0;
      mac_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_icmp_q  <= sel_icmp_d;
      len_q       <= len_d;
      tot_len_q   <= tot_len_d;
      proto_q     <= proto_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      pkt_id_q    <= pkt_id_d;
      id_ctr_q    <= id_ctr_d;
      target_ip_q <= target_ip_d;
      source_ip_q <= source_ip_d;
      hdr_cnt_q   <= hdr_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      hdr_csum_q  <= hdr_csum_d;
      mac_data_q  <= mac_data_d;
      mac_len_q   <= mac_len_d;
      mac_last_q  <= mac_last_d;
      mac_valid_q <= mac_valid_d;
    end
  end

  assign o_mac_data  = mac_data_q;
  assign o_mac_len   = mac_len_q;
  assign o_mac_last  = mac_last_q;
  assign o_mac_valid = mac_valid_q;

endmodule

// File: tb/tb_ip_tx.sv
// Randomized self-checking bench for ip_tx: expected MAC byte stream (data, cycle,
// last, length) is built from header rules and stream acceptances.
module tb_ip_tx;

  typedef struct {
    logic [7:0]  d;
    int          c;
    logic        l;
    logic [15:0] m;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] target_ip = '0;
  logic        target_valid = 1'b0;
  logic [31:0] source_ip = '0;
  logic        source_valid = 1'b0;
  logic [7:0]  udp_data = '0;
  logic [15:0] udp_len = '0;
  logic        udp_last = 1'b0;
  logic        udp_valid = 1'b0;
  logic        udp_ready;
  logic [7:0]  icmp_data = '0;
  logic [15:0] icmp_len = '0;
  logic        icmp_last = 1'b0;
  logic        icmp_valid = 1'b0;
  logic        icmp_ready;
  logic [7:0]  mac_data;
  logic [15:0] mac_len;
  logic        mac_last;
  logic        mac_valid;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          prev_last_cyc = -1;
  logic [31:0] m_tgt = 32'hC0A8_0100;
  logic [31:0] m_src = 32'hC0A8_0101;
  logic [15:0] m_id = '0;
  ent_t        exp_q[$];
  ent_t        rx_q[$];

  ip_tx #(
    .P_ST_TARGET_IP ({8'd192, 8'd168, 8'd1, 8'd0}),
    .P_ST_SOURCE_IP ({8'd192, 8'd168, 8'd1, 8'd1}),
    .P_TTL          (8'd64)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_target_ip    (target_ip),
    .i_target_valid (target_valid),
    .i_source_ip    (source_ip),
    .i_source_valid (source_valid),
    .i_udp_data     (udp_data),
    .i_udp_len      (udp_len),
    .i_udp_last     (udp_last),
    .i_udp_valid    (udp_valid),
    .o_udp_ready    (udp_ready),
    .i_icmp_data    (icmp_data),
    .i_icmp_len     (icmp_len),
    .i_icmp_last    (icmp_last),
    .i_icmp_valid   (icmp_valid),
    .o_icmp_ready   (icmp_ready),
    .o_mac_data     (mac_data),
    .o_mac_len      (mac_len),
    .o_mac_last     (mac_last),
    .o_mac_valid    (mac_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && mac_valid) rx_q.push_back('{mac_data, cyc, mac_last, mac_len});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic rdy(input bit icmp);
    return icmp ? icmp_ready : udp_ready;
  endfunction

  task automatic drive(input bit icmp, input logic v, input logic [7:0] d,
                       input logic l, input logic [15:0] n);
    if (icmp) begin
      icmp_valid = v; icmp_data = d; icmp_last = l; icmp_len = n;
    end else begin
      udp_valid = v; udp_data = d; udp_last = l; udp_len = n;
    end
  endtask

  // Header model: byte 19 is on the MAC port in cycle c19, earlier bytes back to back.
  task automatic push_hdr(input logic [15:0] tot, input logic [15:0] id, input logic [7:0] proto,
                          input logic [31:0] src, input logic [31:0] dst, input int c19);
    logic [7:0]  h[20];
    int unsigned s;
    h = '{8'h45, 8'h00, tot[15:8], tot[7:0], id[15:8], id[7:0], 8'h40, 8'h00, 8'd64, proto,
          8'h00, 8'h00, src[31:24], src[23:16], src[15:8], src[7:0],
          dst[31:24], dst[23:16], dst[15:8], dst[7:0]};
    s = 0;
    for (int i = 0; i < 20; i += 2) s = s + {16'h0, h[i], h[i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    s = ~s & 32'hFFFF;
    h[10] = s[15:8];
    h[11] = s[7:0];
    if (prev_last_cyc >= 0) chk("idle_gap", 32'((c19 - 19 - prev_last_cyc) >= 2), 1);
    for (int i = 0; i < 20; i++) exp_q.push_back('{h[i], c19 - 19 + i, 1'b0, tot});
  endtask

  task automatic send(input bit icmp, input int len, input int last_at, input bit gaps,
                      output bit aborted);
    logic [7:0]  pay[$];
    logic [31:0] src, dst;
    logic [15:0] tot, id;
    logic [7:0]  proto;
    int          n, k, budget, other;
    bit          started, done, v;
    src = m_src; dst = m_tgt;
    tot = 16'(len + 20);
    id = '0;
    proto = icmp ? 8'd1 : 8'd17;
    n = (last_at >= 0 && last_at < len) ? last_at + 1 : len;
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    k = 0; started = 0; done = 0; budget = 400; other = 0; aborted = 0;
    @(negedge clk);
    v = 1;
    drive(icmp, v, pay[0], k == last_at, 16'(len));
    while (1) begin
      #4;
      if (!rst_n) begin aborted = 1; break; end
      if (started && rdy(!icmp)) other++;
      if (v && rdy(icmp)) begin
        if (!started) begin
          started = 1;
`ifdef IP_TX_ID_INC_EN
          id = m_id;
`endif
          push_hdr(tot, id, proto, src, dst, cyc);
        end
        done = (k == last_at) || (k + 1 == len);
        exp_q.push_back('{pay[k], cyc + 1, done, tot});
        if (done) prev_last_cyc = cyc + 1;
        k++;
      end
      budget--;
      if (done || budget == 0) break;
      @(negedge clk);
      v = !(gaps && started && $urandom_range(3) == 0);
      drive(icmp, v, pay[k], k == last_at, 16'(len));
    end
    if (aborted) begin
      drive(icmp, 0, 8'h00, 0, 16'h0);
    end else begin
      if (!done) chk("timeout", 0, 1);
      chk("other_ready", other, 0);
      @(negedge clk);
      drive(icmp, 0, 8'h00, 0, 16'h0);
      #4;
      if (done) chk("ready_drop", 32'(rdy(icmp)), 0);
`ifdef IP_TX_ID_INC_EN
      if (done) m_id = m_id + 16'd1;
`endif
    end
  endtask

  task automatic drain();
    ent_t r, e;
    repeat (3) @(negedge clk);
    chk("byte_count", rx_q.size(), exp_q.size());
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      chk("data", r.d, e.d);
      chk("cycle", r.c, e.c);
      chk("last", r.l, e.l);
      chk("mac_len", r.m, e.m);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_ip(input bit tgt, input logic [31:0] ip);
    @(negedge clk);
    if (tgt) begin target_ip = ip; target_valid = 1; end
    else begin source_ip = ip; source_valid = 1; end
    @(negedge clk);
    target_valid = 0; source_valid = 0;
    if (tgt) m_tgt = ip; else m_src = ip;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, {mac_valid, mac_last, udp_ready, icmp_ready, mac_data, mac_len}, 0);
  endtask

  initial begin
    bit ab, ab2;
    int w;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset_outputs");
    rst_n = 1;

    send(0, 12, 11, 0, ab);
    drain();
    send(1, 8, -1, 0, ab);
    drain();

    fork
      send(1, 8, 7, 0, ab);
      send(0, 12, -1, 1, ab2);
    join
    drain();

    send(0, 12, 4, 1, ab);
    send(0, 12, -1, 1, ab);
    send(1, 1, -1, 0, ab);
    send(0, 16'hFFF5, 3, 0, ab);
    drain();

    fork
      send(0, 12, -1, 0, ab);
      begin
        repeat (8) @(negedge clk);
        target_ip = 32'h0A00_0002; target_valid = 1;
        @(negedge clk);
        target_valid = 0;
      end
    join
    m_tgt = 32'h0A00_0002;
    send(0, 12, -1, 0, ab);
    drain();

    for (int p = 0; p < 24; p++) begin
      int len, la;
      len = $urandom_range(40, 1);
      la  = ($urandom_range(1) == 0) ? -1 : int'($urandom_range(len + 3, 0));
      if ($urandom_range(4) == 0) pulse_ip($urandom_range(1) == 1, $urandom);
      repeat ($urandom_range(3)) @(negedge clk);
      send($urandom_range(1) == 1, len, la, $urandom_range(1) == 1, ab);
      if (p % 6 == 5) drain();
    end
    drain();

    fork
      send(0, 30, -1, 1, ab);
      begin
        w = 0;
        while (!udp_ready && w < 100) begin @(negedge clk); w++; end
        chk("reset_wait", 32'(udp_ready), 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1 chk_outputs_zero("abort_outputs");
        repeat (3) @(negedge clk);
        rst_n = 1;
      end
    join
    chk("aborted", 32'(ab), 1);
    rx_q.delete();
    exp_q.delete();
    prev_last_cyc = -1;
    m_tgt = 32'hC0A8_0100;
    m_src = 32'hC0A8_0101;
    m_id  = '0;

    send(0, 12, -1, 0, ab);
    send(0, 12, -1, 0, ab);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ip_tx.md
Name: ip_tx

Overview:
- IPv4 transmit framer. Sits between the UDP/ICMP transmit layers and the MAC transmit path; it is the send-side counterpart of the IP receive parser.
- Arbitrates one UDP and one ICMP payload stream and builds a 20-byte IPv4 header, including the header checksum.
- Emits header plus payload as one contiguous byte stream to the MAC layer.
- Upper layers are back-pressured with a ready signal while the header is generated.

Parameters:
- P_ST_TARGET_IP, {8'd192,8'd168,8'd1,8'd0}: destination IP after reset.
- P_ST_SOURCE_IP, {8'd192,8'd168,8'd1,8'd1}: local (source) IP after reset.
- P_TTL, 8'd64: TTL field.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_target_ip  in  32  new destination IP.
- i_target_valid  in  1  load i_target_ip.
- i_source_ip  in  32  new local IP.
- i_source_valid  in  1  load i_source_ip.
- i_udp_data  in  8  UDP payload byte.
- i_udp_len  in  16  UDP length in bytes, held stable while i_udp_valid.
- i_udp_last  in  1  final UDP byte.
- i_udp_valid  in  1  UDP byte valid / request.
- o_udp_ready  out  1  UDP byte accepted when valid&&ready.
- i_icmp_data, i_icmp_len, i_icmp_last, i_icmp_valid, o_icmp_ready: same set for ICMP.
- o_mac_data  out  8  IP byte to MAC.
- o_mac_len  out  16  IP total length, valid from the first byte.
- o_mac_last  out  1  final byte of the IP packet.
- o_mac_valid  out  1  byte valid. There is no MAC back-pressure.

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - All outputs 0, FSM to IDLE.
  - IP registers load their parameter defaults.
  - Reset mid-packet aborts the packet with no last pulse.
- IP registers: a valid strobe loads the register next cycle at any time. Values are snapshotted in IDLE at packet start, so an update mid-packet affects only the next packet.
- FSM: IDLE -> SUM -> FOLD -> HEAD -> DATA -> IDLE.
- IDLE:
  - Waits for i_icmp_valid or i_udp_valid; ready is low.
  - ICMP wins when both are pending.
  - Latches selection, len, protocol (1 or 17), IPs and ID.
  - Total length = len+20, truncated to 16 bits.
- SUM (1 cycle): 20-bit sum of the ten header words with checksum=0.
- FOLD (1 cycle): add carry into low 16, fold again, invert -> checksum.
- HEAD (20 cycles): emits header bytes 0..19 in this order:
  - 45, 00
  - total length
  - ID
  - 40 00 (DF)
  - P_TTL
  - protocol
  - checksum
  - source IP
  - target IP
- Payload handoff:
  - Selected ready rises combinationally during header byte 19, then stays high in DATA.
  - An accepted byte appears on o_mac_data registered, one cycle later, so the payload follows header byte 19 with no gap.
  - If upstream valid drops mid-payload, o_mac_valid drops for the same cycles.
- Termination: the packet ends on the first of two events, with o_mac_last on that byte and ready low next cycle:
  - the accepted byte carries the selected last;
  - the payload count reaches len.
- DATA -> IDLE after the last byte. The next SUM can start the cycle after IDLE, so there is at least 1 idle cycle between packets.
- len=0 is illegal; behaviour is undefined.
- The non-selected stream's ready stays 0 for the whole packet.
- o_mac_len holds its value until the next packet start.

Optional Feature:
- IP_TX_ID_INC_EN defined: Identification starts at 0 after reset and increments by 1 (wrapping at 16'hFFFF->0) after each completed packet; aborted packets do not increment it.
- Undefined: Identification is constantly 16'h0000.

Decomposition:
- Package ip_tx_pkg holds:
  - constants C_IP_VER_IHL=8'h45, C_IP_HDR_LEN=20, C_IP_FLAGS=16'h4000;
  - C_PROTO_UDP=8'd17, C_PROTO_ICMP=8'd1;
  - the FSM state enum.
- Sub-module ip_checksum is natural: it takes ten header words, performs the registered sum and fold, and outputs the checksum with a done strobe. It is reusable by the ICMP tx.

Test Plan:
- Reset defaults; UDP len=12 with 12 payload bytes:
  - header 45 00 00 20 00 00 40 00 40 11 B7 7B C0 A8 01 01 C0 A8 01 00;
  - o_mac_len=32; payload contiguous; last on byte 32.
- ICMP len=8: header protocol 01, total 00 1C, checksum B7 8F; o_udp_ready stays 0.
- UDP and ICMP asserted in the same cycle: ICMP sent first; UDP sent after at least 1 idle cycle, with correct header.
- i_udp_last on byte 5 with len=12: o_mac_last on payload byte 5, return to IDLE. Also len=12 with no last: packet ends after 12 bytes and ready drops.
- i_target_valid (10.0.0.2) pulsed during HEAD: current packet keeps 192.168.1.0; next packet carries 0A 00 00 02.
- With IP_TX_ID_INC_EN: two identical UDP len=12 packets give ID 0000 with checksum B77B, then ID 0001 with checksum B77A. Reset asserted mid-payload: outputs 0 immediately, FSM in IDLE.
